weight_load_ctrl: RTL and testbench
===================================

# weight_load_ctrl

Sequencer that fetches every filter's packed weight vector from the per-filter weight ROM instances, one filter at a time, and holds the result for the convolution engine. It sits between the NUM_FILTERS weight ROMs and the conv array. It drives each ROM's `read_enable` / `weight_valid` handshake, captures each filter's packed output into a shared weight bank, and tells the engine when the complete weight set is usable.

## Interface
Parameters:
- `NUM_FILTERS`, 3: number of filter ROMs sequenced.
- `INPUT_CHANNELS`, 3: channels per filter.
- `KERNEL_SIZE`, 3: kernel edge length.
- `WEIGHT_WIDTH`, 8: bits per weight.
- `TIMEOUT_CYCLES`, 256: watchdog limit per handshake phase. Used only with `WEIGHT_LOAD_TIMEOUT_EN`.
- Derived: `WPF = INPUT_CHANNELS*KERNEL_SIZE*KERNEL_SIZE`; `FW = WPF*WEIGHT_WIDTH`.

Ports (one clock `clk`; reset `rst_n` is asynchronous, active-low):
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  load request, sampled each cycle.
- `rom_read_enable`  out  NUM_FILTERS  per-ROM read enable, bit f drives filter f.
- `rom_weight_valid`  in  NUM_FILTERS  per-ROM valid, bit f from filter f.
- `rom_weight_data`  in  NUM_FILTERS*FW  ROM outputs, filter f at bits [(f+1)*FW-1 : f*FW].
- `weight_bank`  out  NUM_FILTERS*FW  captured weights, same packing as `rom_weight_data`.
- `weights_ready`  out  1  level: the bank holds a complete set.
- `busy`  out  1  load in progress.
- `done`  out  1  one-cycle pulse when a load completes.
- `load_error`  out  1  sticky watchdog error.

## Operation
- States: IDLE, REQ, RELEASE, DONE. A filter index `idx` runs from 0 to NUM_FILTERS-1.
- IDLE:
  - `start`=1 moves to REQ with `idx`=0 and `rom_read_enable[0]`<=1.
  - `weights_ready`<=0, `load_error`<=0, `busy`<=1.
- REQ: holds `rom_read_enable[idx]` high. When `rom_weight_valid[idx]`=1 is sampled:
  - copy slice `idx` of `rom_weight_data` into slice `idx` of `weight_bank`;
  - clear `rom_read_enable[idx]`;
  - go to RELEASE.
- RELEASE: waits for `rom_weight_valid[idx]`=0. The ROM cannot re-arm while valid is high. Then:
  - if `idx` < NUM_FILTERS-1: `idx`+1, assert the next enable, go to REQ;
  - otherwise go to DONE.
- DONE:
  - `done`=1 for one cycle;
  - `weights_ready`<=1, `busy`<=0;
  - return to IDLE.
- At most one `rom_read_enable` bit is high at any time. Bits other than `idx` are always 0.
- `rom_weight_valid` bits other than `idx` are ignored.
- `start` while `busy`=1 is ignored. It is not queued.
- `start` in the same cycle as DONE is ignored. It is accepted from IDLE on the next cycle.
- A reload (start while `weights_ready`=1) clears `weights_ready` immediately.
- During a reload, `weight_bank` slices not yet reloaded keep their previous values.
- Reset (including mid-load):
  - all outputs are 0, `weight_bank` is 0;
  - state is IDLE, `idx`=0.

## Timing
- All outputs are registered. No combinational input-to-output paths.
- Start accepted at edge S: `rom_read_enable[0]`=1 and `busy`=1 after S.
- Capture happens on the edge that samples valid high. The enable is low after that same edge.
- Per-filter cost = ROM valid latency + 3 cycles. With the team ROM (valid at WPF+2 edges after enable), that is WPF+5 cycles.
- `done` and `weights_ready` rise after edge S + NUM_FILTERS*(WPF+5).

## Configuration
- `WEIGHT_LOAD_TIMEOUT_EN` defined:
  - a counter resets on each REQ or RELEASE entry and counts cycles in that state;
  - reaching `TIMEOUT_CYCLES` sets `load_error`=1, clears all enables, sets `busy`=0, returns to IDLE without `done`;
  - `weights_ready` stays 0;
  - `load_error` clears on the next accepted `start`.
- Not defined: no counter exists, `load_error` is tied to 0, and the block waits indefinitely.

## Test plan
- **Basic load.** Reset, then 3 ROM models (WPF=27, filter f data = bytes f*27..f*27+26). Pulse `start`. Required: enables assert one at a time in order 0,1,2; `done` pulses at S+96; `weights_ready`=1; `weight_bank` bytes are 0..80.
- **Start while busy.** Pulse `start` at S+10 and at S+96 (the DONE cycle). Required: no restart, a single `done`, and bank contents unchanged from the basic load.
- **Slow valid drop.** The ROM holds valid 4 extra cycles after enable falls. Required: the next enable stays low until valid falls, and total latency grows by 4 per filter.
- **Reset mid-load.** Assert `rst_n`=0 at S+40. Required: all outputs and the bank read 0 immediately; a new `start` gives a correct full load.
- **Reload.** After a load, change the ROM 1 data to 0xFF and pulse `start`. Required: `weights_ready` drops after the start edge; only slice 1 changes; `weights_ready` returns high at +96.
- **Timeout (macro on, TIMEOUT_CYCLES=50).** ROM 1 never asserts valid. Required: `load_error`=1 and all enables 0 50 cycles after REQ entry for filter 1; no `done`; `weights_ready`=0; the next `start` clears `load_error`.

Source files
------------

// File: rtl/weight_load_ctrl.sv
// Weight-load sequencer: walks the per-filter weight ROMs one at a time and captures each packed vector into a shared bank.
// Optional watchdog per handshake phase is enabled by defining WEIGHT_LOAD_TIMEOUT_EN.
module weight_load_ctrl #(
    parameter int NUM_FILTERS    = 3,
    parameter int INPUT_CHANNELS = 3,
    parameter int KERNEL_SIZE    = 3,
    parameter int WEIGHT_WIDTH   = 8,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                                                                         clk,
    input  logic                                                                         rst_n,
    input  logic                                                                         start,
    output logic [NUM_FILTERS-1:0]                                                       rom_read_enable,
    input  logic [NUM_FILTERS-1:0]                                                       rom_weight_valid,
    input  logic [NUM_FILTERS*INPUT_CHANNELS*KERNEL_SIZE*KERNEL_SIZE*WEIGHT_WIDTH-1:0]  rom_weight_data,
    output logic [NUM_FILTERS*INPUT_CHANNELS*KERNEL_SIZE*KERNEL_SIZE*WEIGHT_WIDTH-1:0]  weight_bank,
    output logic                                                                         weights_ready,
    output logic                                                                         busy,
    output logic                                                                         done,
    output logic                                                                         load_error
);

    localparam int WPF  = INPUT_CHANNELS * KERNEL_SIZE * KERNEL_SIZE;
    localparam int FW   = WPF * WEIGHT_WIDTH;
    localparam int IDXW = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RELEASE,
        DONE
    } state_e;

    state_e                     state_q, state_d;
    logic [IDXW-1:0]            idx_q, idx_d;
    logic [NUM_FILTERS-1:0]     en_q, en_d;
    logic [NUM_FILTERS*FW-1:0]  bank_q, bank_d;
    logic                       ready_q, ready_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic                       valid_cur;
    logic                       last_idx;
    logic                       timeout;
    logic                       abort;

    if (NUM_FILTERS < 1 || TIMEOUT_CYCLES < 2) begin : g_bad_config
        $error("weight_load_ctrl: NUM_FILTERS must be >= 1 and TIMEOUT_CYCLES >= 2");
    end

    always_comb begin
        valid_cur = rom_weight_valid[idx_q];
        last_idx  = (idx_q == IDXW'(NUM_FILTERS - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            en_q    <= '0;
            bank_q  <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            en_q    <= en_d;
            bank_q  <= bank_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // A ROM cannot re-arm while its valid is high, so RELEASE waits for the drop before moving on.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = REQ;
                    idx_d   = '0;
                end
            end
            REQ: begin
                if (valid_cur) begin
                    state_d = RELEASE;
                end else if (timeout) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end
            end
            RELEASE: begin
                if (!valid_cur) begin
                    if (last_idx) begin
                        state_d = DONE;
                    end else begin
                        state_d = REQ;
                        idx_d   = idx_q + 1'b1;
                    end
                end else if (timeout) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end
            end
            DONE: begin
                state_d = IDLE;
                idx_d   = '0;
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_comb begin
        abort = ((state_q == REQ) || (state_q == RELEASE)) && (state_d == IDLE);
    end

    // Outputs are computed one cycle ahead so every port comes straight from a flop.
    always_comb begin
        en_d    = en_q;
        bank_d  = bank_q;
        ready_d = ready_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    en_d    = '0;
                    en_d[0] = 1'b1;
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            REQ: begin
                if (valid_cur) begin
                    for (int f = 0; f < NUM_FILTERS; f++) begin
                        if (f == int'(idx_q)) begin
                            bank_d[f*FW +: FW] = rom_weight_data[f*FW +: FW];
                        end
                    end
                    en_d = '0;
                end else if (abort) begin
                    en_d   = '0;
                    busy_d = 1'b0;
                end
            end
            RELEASE: begin
                if (state_d == REQ) begin
                    for (int f = 0; f < NUM_FILTERS; f++) begin
                        en_d[f] = (f == int'(idx_q) + 1);
                    end
                end else if (state_d == DONE) begin
                    done_d  = 1'b1;
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                end else if (abort) begin
                    en_d   = '0;
                    busy_d = 1'b0;
                end
            end
            default: begin
            end
        endcase
    end

`ifdef WEIGHT_LOAD_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] tcnt_q, tcnt_d;
    logic          err_q, err_d;

    always_comb begin
        timeout = ((state_q == REQ) || (state_q == RELEASE)) && (tcnt_q == CW'(TIMEOUT_CYCLES - 1));
    end

    // The watchdog restarts on every phase entry, so each handshake half gets its own budget.
    always_comb begin
        tcnt_d = tcnt_q + 1'b1;
        if ((state_d != state_q) || (state_q == IDLE) || (state_q == DONE)) begin
            tcnt_d = '0;
        end
        err_d = err_q;
        if ((state_q == IDLE) && start) begin
            err_d = 1'b0;
        end else if (abort) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt_q <= '0;
            err_q  <= 1'b0;
        end else begin
            tcnt_q <= tcnt_d;
            err_q  <= err_d;
        end
    end

    assign load_error = err_q;
`else
    always_comb begin
        timeout = 1'b0;
    end

    assign load_error = 1'b0;
`endif

    assign rom_read_enable = en_q;
    assign weight_bank     = bank_q;
    assign weights_ready   = ready_q;
    assign busy            = busy_q;
    assign done            = done_q;

endmodule

// File: tb/tb_weight_load_ctrl.sv
// Scoreboard bench for weight_load_ctrl: behavioural ROM models plus a queue of expected load completions.
module tb_weight_load_ctrl;

    localparam int N   = 3;
    localparam int IC  = 3;
    localparam int K   = 3;
    localparam int WW  = 8;
    localparam int TO  = 50;
    localparam int WPF = IC * K * K;
    localparam int FW  = WPF * WW;

    typedef struct {
        int               cyc;
        logic [N*FW-1:0]  bank;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [N-1:0]      en;
    logic [N-1:0]      valid;
    logic [N*FW-1:0]   romData;
    logic [N*FW-1:0]   bank;
    logic              ready, busy, done, err;

    logic [WW-1:0]     romMem [N][WPF];
    int                romHold [N];
    bit                romNever [N];
    int                romCnt [N];
    int                holdLeft [N];

    exp_t              sbQ[$];
    int                cyc = 0;
    int                checks = 0;
    int                errors = 0;
    int                expIdx = 0;
    logic [N-1:0]      prevEn = '0;
    logic [N*FW-1:0]   basicBank;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    weight_load_ctrl #(
        .NUM_FILTERS(N), .INPUT_CHANNELS(IC), .KERNEL_SIZE(K),
        .WEIGHT_WIDTH(WW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .rom_read_enable(en), .rom_weight_valid(valid), .rom_weight_data(romData),
        .weight_bank(bank), .weights_ready(ready), .busy(busy), .done(done), .load_error(err)
    );

    always_comb begin
        romData = '0;
        for (int f = 0; f < N; f++)
            for (int w = 0; w < WPF; w++)
                romData[(f*WPF + w)*WW +: WW] = romMem[f][w];
    end

    // ROM model: valid rises WPF+2 edges after enable, falls one edge after enable drops plus romHold extra cycles.
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int f = 0; f < N; f++) begin
                romCnt[f] = 0;
                holdLeft[f] = 0;
                valid[f] = 1'b0;
            end
        end else begin
            for (int f = 0; f < N; f++) begin
                if (en[f] && !romNever[f]) begin
                    romCnt[f] = romCnt[f] + 1;
                    if (romCnt[f] == WPF + 3) valid[f] = 1'b1;
                    holdLeft[f] = romHold[f] + 2;
                end else begin
                    romCnt[f] = 0;
                    if (valid[f]) begin
                        holdLeft[f] = holdLeft[f] - 1;
                        if (holdLeft[f] <= 0) valid[f] = 1'b0;
                    end
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [N*FW-1:0] act, input logic [N*FW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [N*FW-1:0] modelBank();
        logic [N*FW-1:0] v = '0;
        for (int f = 0; f < N; f++)
            for (int w = 0; w < WPF; w++)
                v[(f*WPF + w)*WW +: WW] = romMem[f][w];
        return v;
    endfunction

    function automatic int modelLatency();
        int lat = 0;
        for (int f = 0; f < N; f++) lat += (WPF + 2) + 3 + romHold[f];
        return lat;
    endfunction

    // Monitor: enable ordering, one-hot enables and scoreboard pop on every done pulse.
    always @(negedge clk) begin
        exp_t e;
        logic [N-1:0] expEn;
        if (!rst_n) begin
            prevEn = '0;
        end else begin
            checkOutput("en_onehot", (N*FW)'($countones(en) <= 1), (N*FW)'(1));
            if (en != '0 && en != prevEn) begin
                expEn = '0;
                if (expIdx < N) expEn[expIdx] = 1'b1;
                checkOutput("en_order", (N*FW)'(en), (N*FW)'(expEn));
                expIdx++;
            end
            prevEn = en;
            if (done) begin
                if (sbQ.size() == 0) begin
                    checkOutput("unexpected_done", (N*FW)'(1), (N*FW)'(0));
                end else begin
                    e = sbQ.pop_front();
                    checkOutput("done_cycle", (N*FW)'(cyc), (N*FW)'(e.cyc));
                    checkOutput("bank", bank, e.bank);
                    checkOutput("ready_at_done", (N*FW)'(ready), (N*FW)'(1));
                    checkOutput("busy_at_done", (N*FW)'(busy), (N*FW)'(0));
                end
            end
        end
    end

    task automatic applyStimulus(input int gap, input bit expectDone, output int s);
        exp_t e;
        repeat (gap) @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        s = cyc;
        expIdx = 0;
        if (expectDone) begin
            e.cyc = s + modelLatency();
            e.bank = modelBank();
            sbQ.push_back(e);
        end
        checkOutput("ready_after_start", (N*FW)'(ready), (N*FW)'(0));
        checkOutput("busy_after_start", (N*FW)'(busy), (N*FW)'(1));
        checkOutput("err_after_start", (N*FW)'(err), (N*FW)'(0));
        checkOutput("en_after_start", (N*FW)'(en), (N*FW)'(1));
    endtask

    task automatic waitIdle(input int budget);
        int n = 0;
        while (sbQ.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (sbQ.size() != 0) begin
            checkOutput("load_timeout", (N*FW)'(sbQ.size()), (N*FW)'(0));
            sbQ.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic waitCycle(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_en"}, (N*FW)'(en), '0);
        checkOutput({tag, "_bank"}, bank, '0);
        checkOutput({tag, "_ready"}, (N*FW)'(ready), '0);
        checkOutput({tag, "_busy"}, (N*FW)'(busy), '0);
        checkOutput({tag, "_done"}, (N*FW)'(done), '0);
        checkOutput({tag, "_err"}, (N*FW)'(err), '0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL global_watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int s;
        logic [N*FW-1:0] expV;
        rst_n = 1'b0;
        start = 1'b0;
        for (int f = 0; f < N; f++) begin
            romHold[f] = 0;
            romNever[f] = 1'b0;
            for (int w = 0; w < WPF; w++) romMem[f][w] = WW'(f*WPF + w);
        end
        basicBank = '0;
        for (int b = 0; b < N*WPF; b++) basicBank[b*WW +: WW] = WW'(b);

        repeat (3) @(negedge clk);
        checkAllZero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] basic load");
        applyStimulus(0, 1'b1, s);
        waitIdle(400);
        checkOutput("basic_bytes", bank, basicBank);
        checkOutput("basic_ready", (N*FW)'(ready), (N*FW)'(1));

        $display("[TB] start while busy and in DONE");
        applyStimulus(1, 1'b1, s);
        waitCycle(s + 9);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitCycle(s + 96);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitCycle(s + 98);
        checkOutput("no_restart_busy", (N*FW)'(busy), '0);
        checkOutput("no_restart_en", (N*FW)'(en), '0);
        waitIdle(400);
        checkOutput("busy_bank", bank, basicBank);

        $display("[TB] slow valid drop");
        for (int f = 0; f < N; f++) romHold[f] = 4;
        applyStimulus(2, 1'b1, s);
        waitIdle(400);
        for (int f = 0; f < N; f++) romHold[f] = 0;

        $display("[TB] reset mid-load");
        applyStimulus(1, 1'b1, s);
        waitCycle(s + 40);
        rst_n = 1'b0;
        sbQ.delete();
        #1;
        checkAllZero("midreset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1, 1'b1, s);
        waitIdle(400);
        checkOutput("after_reset_bank", bank, basicBank);

        $display("[TB] reload with changed ROM 1");
        for (int w = 0; w < WPF; w++) romMem[1][w] = 8'hFF;
        applyStimulus(1, 1'b1, s);
        waitCycle(s + 40);
        checkOutput("reload_partial", bank, basicBank);
        waitIdle(400);
        expV = basicBank;
        for (int w = 0; w < WPF; w++) expV[(WPF + w)*WW +: WW] = 8'hFF;
        checkOutput("reload_bank", bank, expV);

        $display("[TB] randomized loads");
        for (int t = 0; t < 4; t++) begin
            for (int f = 0; f < N; f++) begin
                romHold[f] = int'($urandom_range(0, 3));
                for (int w = 0; w < WPF; w++) romMem[f][w] = WW'($urandom);
            end
            applyStimulus(int'($urandom_range(0, 5)), 1'b1, s);
            waitIdle(400);
        end
        for (int f = 0; f < N; f++) romHold[f] = 0;

`ifdef WEIGHT_LOAD_TIMEOUT_EN
        $display("[TB] watchdog on filter 1");
        romNever[1] = 1'b1;
        applyStimulus(1, 1'b0, s);
        waitCycle(s + 81);
        checkOutput("err_before_limit", (N*FW)'(err), '0);
        waitCycle(s + 82);
        checkOutput("err_at_limit", (N*FW)'(err), (N*FW)'(1));
        checkOutput("en_at_limit", (N*FW)'(en), '0);
        checkOutput("busy_at_limit", (N*FW)'(busy), '0);
        checkOutput("ready_at_limit", (N*FW)'(ready), '0);
        repeat (10) @(negedge clk);
        romNever[1] = 1'b0;
        applyStimulus(1, 1'b1, s);
        waitIdle(400);
`endif

        checkOutput("sb_empty", (N*FW)'(sbQ.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
